lmg_move_packer: RTL and testbench
==================================

// Module: lmg_move_packer
// PURPOSE
//  Producer end of the LMG move FIFO. Accepts single 18-bit moves from the move generator core
//  and packs them eight per 152-bit word into an internal FIFO. Drives done/fifoOut/rden/fifoEmpty
//  toward the controller, which drains words until it reads an all-invalid terminator word.
// PARAMETERS
//  MOVE_W      18   width of one move payload
//  SLOTS       8    moves per FIFO word; word width = SLOTS*(MOVE_W+1) = 152
//  DEPTH_LOG2  4    FIFO depth = 16 words
// PORTS
//  clk        in   1    system clock
//  reset      in   1    asynchronous, active-high; also restarts generation (controller pulses it)
//  mv_valid   in   1    mv_data holds a move
//  mv_data    in   18   move payload
//  mv_ready   out  1    packer accepts move this cycle
//  gen_last   in   1    generation finished; may coincide with the final mv_valid or arrive alone
//  rden       in   1    controller read request, one word per asserted cycle
//  fifoOut    out  152  registered read word
//  fifoEmpty  out  1    no stored words
//  done       out  1    terminator word committed; generation complete
// BEHAVIOUR
//  Word format: slot k = bits [19k+17:19k] move, bit 19k+18 invalid flag (1 = empty).
//   Slot 0 is filled first. INVALID_WORD = every invalid flag 1, payloads 0.
//  Reset values: fifoOut=INVALID_WORD, fifoEmpty=1, done=0, mv_ready=0. Pointers, count, slot
//   index=0. Pack register=INVALID_WORD. State=COLLECT on the first edge after reset deasserts.
//  FSM: COLLECT -> FLUSH -> TERM -> DONE. DONE holds until reset.
//   COLLECT: mv_ready = (count < DEPTH). Accept = mv_valid & mv_ready: payload -> slot idx,
//    its invalid bit cleared, idx++. Accepting slot 7 commits the completed word, including
//    this move, to the FIFO on the same edge. Pack register -> INVALID_WORD, idx -> 0.
//    gen_last (with or without accept) -> FLUSH. A move accepted that cycle is packed first.
//   FLUSH: mv_ready=0. If idx!=0, commit the partial word (unused slots invalid) when
//    count<DEPTH, then go to TERM. If idx==0, go directly to TERM.
//   TERM: mv_ready=0. Push INVALID_WORD when count<DEPTH, then go to DONE.
//   DONE: done=1, mv_ready=0.
//  Read: fifoOut updates the edge after rden is sampled, giving 1-cycle latency.
//   rden & !fifoEmpty: fifoOut<=mem[rd_ptr], rd_ptr++.
//   rden & fifoEmpty: fifoOut<=INVALID_WORD, pointers unchanged.
//   !rden: fifoOut holds.
//  Simultaneous commit and read in the same cycle: both occur, count unchanged. Reading a word
//   committed in the same cycle is not allowed; the empty rule applies.
//  count is DEPTH_LOG2+1 bits; pointers wrap modulo DEPTH. Overflow cannot occur: all pushes
//   are gated by count<DEPTH. fifoEmpty = (count==0), combinational from registered count.
//  A terminator is always pushed, including when zero moves are generated, so the controller
//   ends on an all-invalid word regardless of whether the last move word was full.
//  Reset asserted mid-operation discards stored words, the partial word, and done immediately.
// CONFIGURATION
//  LMG_PACK_COUNT_EN defined: adds output move_count[7:0], reset 0, incremented per accepted
//   move, saturating at 255, held after done. Lets the controller cross-check its writeCount.
//  Undefined: the port is absent and no counter logic is built.
// TESTING
//  3 moves (0x00001,0x00002,0x00003), gen_last with 3rd -> rden: word slots0-2 those moves,
//   slots3-7 invalid; next rden -> INVALID_WORD; done=1 two cycles after gen_last.
//  Exactly 8 moves then gen_last alone -> word0 all valid (bits 18,37..151 = 0), word1 INVALID_WORD,
//   no partial flush.
//  Zero moves, gen_last at cycle 1 -> single INVALID_WORD stored; rden on empty also INVALID_WORD.
//  rden held low, 136 moves stream in -> mv_ready drops once count=16 after the 128th move;
//   draining one word reasserts it next cycle; no move lost, order preserved.
//  Accept of slot 7 in the same cycle as rden of the last stored word -> count stays 1, fifoEmpty stays 0.
//  reset pulse mid-stream (5 words stored) -> fifoEmpty=1, done=0, fifoOut=INVALID_WORD, fresh packing.

Source files
------------

// File: rtl/lmg_move_packer_if.sv
// ---------------------------------------------------------------------------
// lmg_move_packer_if
// Bundles the move-generator handshake and the controller read bus of the
// LMG move packer.
//   master : environment side (move generator + controller)
//   slave  : packer side
// Signals
//   mv_valid   generator -> packer  mv_data holds a move
//   mv_data    generator -> packer  move payload [MOVE_W-1:0]
//   mv_ready   packer -> generator  move accepted this cycle when valid
//   gen_last   generator -> packer  generation finished
//   rden       controller -> packer read one word
//   fifoOut    packer -> controller registered read word [SLOTS*(MOVE_W+1)-1:0]
//   fifoEmpty  packer -> controller no stored words
//   done       packer -> controller terminator committed
//   move_count packer -> controller accepted-move counter (LMG_PACK_COUNT_EN only)
// ---------------------------------------------------------------------------
interface lmg_move_packer_if #(
  parameter int MOVE_W = 18,
  parameter int SLOTS  = 8
);
  localparam int WORD_W = SLOTS * (MOVE_W + 1);

  logic              mv_valid;
  logic [MOVE_W-1:0] mv_data;
  logic              mv_ready;
  logic              gen_last;
  logic              rden;
  logic [WORD_W-1:0] fifoOut;
  logic              fifoEmpty;
  logic              done;
`ifdef LMG_PACK_COUNT_EN
  logic [7:0]        move_count;
`endif

  modport master (
    output mv_valid, mv_data, gen_last, rden,
`ifdef LMG_PACK_COUNT_EN
    input  move_count,
`endif
    input  mv_ready, fifoOut, fifoEmpty, done
  );

  modport slave (
    input  mv_valid, mv_data, gen_last, rden,
`ifdef LMG_PACK_COUNT_EN
    output move_count,
`endif
    output mv_ready, fifoOut, fifoEmpty, done
  );
endinterface

// File: rtl/lmg_move_packer.sv
// ---------------------------------------------------------------------------
// lmg_move_packer
// Producer end of the LMG move FIFO. Single moves from the move generator are
// packed SLOTS per word (slot 0 first) into an internal FIFO. Each slot is
// {invalid_flag, payload}; an unused slot has its flag set and payload zero.
// After generation ends the partial word (if any) and an all-invalid
// terminator word are pushed, then done is raised until the next reset.
//
// Ports
//   clk    in  system clock
//   reset  in  asynchronous, active-high; clears FIFO, partial word and done
//   bus    slave modport of lmg_move_packer_if (handshake + read bus)
//
// Optional feature
//   LMG_PACK_COUNT_EN : when defined, drives bus.move_count, an 8-bit
//                       saturating count of accepted moves. When undefined
//                       no counter logic is built.
// ---------------------------------------------------------------------------
module lmg_move_packer #(
  parameter int MOVE_W     = 18,
  parameter int SLOTS      = 8,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic             clk,
  input  logic             reset,
  lmg_move_packer_if.slave bus
);

  localparam int SLOT_W = MOVE_W + 1;
  localparam int WORD_W = SLOTS * SLOT_W;
  localparam int DEPTH  = 1 << DEPTH_LOG2;
  localparam int IDX_W  = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  localparam int CNT_W  = DEPTH_LOG2 + 1;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SLOTS - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  // All invalid flags set, all payloads zero.
  function automatic logic [WORD_W-1:0] invalid_word();
    logic [WORD_W-1:0] w;
    w = '0;
    for (int k = 0; k < SLOTS; k++) begin
      w[k*SLOT_W + MOVE_W] = 1'b1;
    end
    return w;
  endfunction

  localparam logic [WORD_W-1:0] INVALID_WORD = invalid_word();

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_FLUSH,
    ST_TERM,
    ST_DONE
  } state_t;

  // Control / data registers
  state_t                  state_q,    state_d;
  logic [IDX_W-1:0]        idx_q,      idx_d;
  logic [WORD_W-1:0]       pack_q,     pack_d;
  logic [DEPTH_LOG2-1:0]   wr_ptr_q,   wr_ptr_d;
  logic [DEPTH_LOG2-1:0]   rd_ptr_q,   rd_ptr_d;
  logic [CNT_W-1:0]        count_q,    count_d;
  logic [WORD_W-1:0]       fifo_out_q, fifo_out_d;
  logic                    done_q,     done_d;
  logic [WORD_W-1:0]       mem_q [DEPTH];

  // Per-cycle decisions
  logic                    has_room;
  logic                    accept;
  logic                    push;
  logic                    pop;
  logic [WORD_W-1:0]       push_word;

  assign has_room = (count_q < FULL_CNT);

  // -------------------------------------------------------------------------
  // Packing FSM: decides accepts and which word (if any) is committed.
  // -------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    pack_d    = pack_q;
    done_d    = done_q;
    accept    = 1'b0;
    push      = 1'b0;
    push_word = INVALID_WORD;

    case (state_q)
      ST_IDLE: begin
        state_d = ST_COLLECT;
      end

      ST_COLLECT: begin
        accept = bus.mv_valid && has_room;
        if (accept) begin
          pack_d[idx_q*SLOT_W +: SLOT_W] = {1'b0, bus.mv_data};
          if (idx_q == LAST_IDX) begin
            // Word is full including this move: commit it on this edge.
            push      = 1'b1;
            push_word = pack_d;
            pack_d    = INVALID_WORD;
            idx_d     = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
        // A move accepted alongside gen_last has already been packed above.
        if (bus.gen_last) begin
          state_d = ST_FLUSH;
        end
      end

      ST_FLUSH: begin
        if (idx_q == '0) begin
          state_d = ST_TERM;
        end else if (has_room) begin
          push      = 1'b1;
          push_word = pack_q;
          pack_d    = INVALID_WORD;
          idx_d     = '0;
          state_d   = ST_TERM;
        end
      end

      ST_TERM: begin
        if (has_room) begin
          push      = 1'b1;
          push_word = INVALID_WORD;
          done_d    = 1'b1;
          state_d   = ST_DONE;
        end
      end

      ST_DONE: begin
        done_d = 1'b1;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // FIFO bookkeeping and read port. The empty test uses the registered count,
  // so a word committed this cycle cannot be read this cycle.
  // -------------------------------------------------------------------------
  always_comb begin
    pop        = bus.rden && (count_q != '0);
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    fifo_out_d = fifo_out_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end

    if (pop) begin
      rd_ptr_d   = rd_ptr_q + 1'b1;
      fifo_out_d = mem_q[rd_ptr_q];
    end else if (bus.rden) begin
      fifo_out_d = INVALID_WORD;
    end

    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (!push && pop) begin
      count_d = count_q - 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // Register stage
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      pack_q     <= INVALID_WORD;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      fifo_out_q <= INVALID_WORD;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      pack_q     <= pack_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      fifo_out_q <= fifo_out_d;
      done_q     <= done_d;
    end
  end

  // Storage is not reset: discarding contents is done through the pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= push_word;
    end
  end

  assign bus.mv_ready  = (state_q == ST_COLLECT) && has_room;
  assign bus.fifoOut   = fifo_out_q;
  assign bus.fifoEmpty = (count_q == '0);
  assign bus.done      = done_q;

`ifdef LMG_PACK_COUNT_EN
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic [7:0] move_count_q, move_count_d;

  // Accepts only happen while collecting, so the count holds after done.
  always_comb begin
    move_count_d = move_count_q;
    if (accept) begin
      move_count_d = sat_inc(move_count_q);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      move_count_q <= '0;
    end else begin
      move_count_q <= move_count_d;
    end
  end

  assign bus.move_count = move_count_q;
`endif

endmodule

// File: tb/tb_lmg_move_packer.sv
module tb_lmg_move_packer;
  localparam int MOVE_W = 18;
  localparam int SLOTS  = 8;
  localparam int WORD_W = SLOTS * (MOVE_W + 1);

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [MOVE_W-1:0] move_t;

  typedef struct {
    int n;            // moves to send
    bit gl_with;      // gen_last together with the final move
    int exp_words;    // words expected in the FIFO, terminator included
    int exp_last_val; // valid slots in the last non-terminator word
  } vec_t;

  logic clk;
  logic reset;

  lmg_move_packer_if #(.MOVE_W(MOVE_W), .SLOTS(SLOTS)) bus ();

  lmg_move_packer #(.MOVE_W(MOVE_W), .SLOTS(SLOTS), .DEPTH_LOG2(4)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int    n_chk  = 0;
  int    n_fail = 0;
  move_t acc_q[$];
  word_t got_q[$];
  word_t exp_q[$];
  word_t INV;
  vec_t  tbl[7];

  function automatic word_t inv_word();
    word_t w;
    w = '0;
    for (int k = 0; k < SLOTS; k++) w[19*k+18] = 1'b1;
    return w;
  endfunction

  // Word made of up to SLOTS accepted moves starting at index 'first'.
  function automatic word_t pack_group(input int first);
    word_t w;
    w = inv_word();
    for (int k = 0; k < SLOTS; k++) begin
      if (first + k < acc_q.size()) begin
        w[19*k +: 18] = acc_q[first+k];
        w[19*k+18]    = 1'b0;
      end
    end
    return w;
  endfunction

  task automatic chk(input string name, input word_t act, input word_t exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic chk_i(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // One clock: records accepted moves and words read from a non-empty FIFO.
  task automatic step();
    logic  p_rd, p_empty, p_acc;
    move_t p_data;
    p_rd    = bus.rden;
    p_empty = bus.fifoEmpty;
    p_acc   = bus.mv_valid && bus.mv_ready;
    p_data  = bus.mv_data;
    @(posedge clk);
    #1;
    if (p_acc) acc_q.push_back(p_data);
    if (p_rd && !p_empty) got_q.push_back(bus.fifoOut);
    if (p_rd && p_empty) chk("empty_read", bus.fifoOut, INV);
  endtask

  task automatic do_reset();
    bus.mv_valid = 1'b0;
    bus.gen_last = 1'b0;
    bus.rden     = 1'b0;
    bus.mv_data  = '0;
    reset = 1'b1;
    #1;
    chk_i("rst_fifoEmpty", int'(bus.fifoEmpty), 1);
    chk_i("rst_done", int'(bus.done), 0);
    chk("rst_fifoOut", bus.fifoOut, INV);
    chk_i("rst_mv_ready", int'(bus.mv_ready), 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk_i("rst_idle_ready", int'(bus.mv_ready), 0);
    acc_q.delete();
    got_q.delete();
    step();
    chk_i("collect_ready", int'(bus.mv_ready), 1);
  endtask

  task automatic drain_until_done(input string name, input int budget, input bit rand_rd);
    int c;
    c = 0;
    bus.mv_valid = 1'b0;
    bus.gen_last = 1'b0;
    while (!(bus.done && bus.fifoEmpty) && c < budget) begin
      bus.rden = rand_rd ? 1'($urandom_range(0, 1)) : 1'b1;
      step();
      c++;
    end
    bus.rden = 1'b0;
    chk_i({name, "_finish_bound"}, int'(bus.done && bus.fifoEmpty), 1);
  endtask

  // Expected stream: moves in order, SLOTS per word, then one terminator.
  task automatic compare_stream(input string name);
    exp_q.delete();
    for (int i = 0; i < acc_q.size(); i += SLOTS) exp_q.push_back(pack_group(i));
    exp_q.push_back(INV);
    chk_i({name, "_words"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk({name, "_word"}, got_q[i], exp_q[i]);
`ifdef LMG_PACK_COUNT_EN
    chk_i({name, "_move_count"}, int'(bus.move_count), (acc_q.size() > 255) ? 255 : acc_q.size());
`endif
  endtask

  initial begin
    #1800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int    nv;
    int    n_rand;
    bit    gl_sent;
    word_t w;

    INV = inv_word();
    tbl[0] = '{3, 1'b1, 2, 3};
    tbl[1] = '{8, 1'b0, 2, 8};
    tbl[2] = '{0, 1'b0, 1, 0};
    tbl[3] = '{8, 1'b1, 2, 8};
    tbl[4] = '{9, 1'b1, 3, 1};
    tbl[5] = '{16, 1'b0, 3, 8};
    tbl[6] = '{1, 1'b0, 2, 1};

    reset        = 1'b0;
    bus.mv_valid = 1'b0;
    bus.gen_last = 1'b0;
    bus.rden     = 1'b0;
    bus.mv_data  = '0;
    #2;

    // Read hold and read-on-empty behaviour
    do_reset();
    for (int i = 0; i < 8; i++) begin
      bus.mv_valid = 1'b1;
      bus.mv_data  = move_t'(32'h2AAA0 + i);
      step();
    end
    bus.mv_valid = 1'b0;
    bus.rden = 1'b1;
    step();
    bus.rden = 1'b0;
    chk("hold_read_word", bus.fifoOut, pack_group(0));
    step();
    step();
    chk("hold_no_rden", bus.fifoOut, pack_group(0));
    bus.rden = 1'b1;
    step();
    bus.rden = 1'b0;
    chk("empty_read_invalid", bus.fifoOut, INV);
    chk_i("empty_after_read", int'(bus.fifoEmpty), 1);

    // Table-driven packing scenarios
    for (int t = 0; t < 7; t++) begin
      do_reset();
      for (int i = 0; i < tbl[t].n; i++) begin
        bus.mv_valid = 1'b1;
        bus.mv_data  = move_t'((t << 12) + i + 1);
        bus.gen_last = tbl[t].gl_with && (i == tbl[t].n - 1);
        step();
      end
      bus.mv_valid = 1'b0;
      if (!(tbl[t].gl_with && tbl[t].n > 0)) begin
        bus.gen_last = 1'b1;
        step();
      end
      bus.gen_last = 1'b0;
      step();
      chk_i("tbl_done_early", int'(bus.done), 0);
      step();
      chk_i("tbl_done_latency", int'(bus.done), 1);
      drain_until_done("tbl", 64, 1'b0);
      chk_i("tbl_exp_words", got_q.size(), tbl[t].exp_words);
      compare_stream("tbl");
      if (tbl[t].exp_words > 1 && got_q.size() >= tbl[t].exp_words) begin
        w  = got_q[tbl[t].exp_words-2];
        nv = 0;
        for (int k = 0; k < SLOTS; k++) if (w[19*k+18] == 1'b0) nv++;
        chk_i("tbl_last_valid", nv, tbl[t].exp_last_val);
      end
      bus.rden = 1'b1;
      step();
      bus.rden = 1'b0;
    end

    // Slot-7 commit in the same cycle as reading the only stored word
    do_reset();
    for (int i = 0; i < 15; i++) begin
      bus.mv_valid = 1'b1;
      bus.mv_data  = move_t'(32'h1000 + i);
      step();
    end
    bus.mv_data = move_t'(32'h1000 + 15);
    bus.rden    = 1'b1;
    step();
    bus.mv_valid = 1'b0;
    chk_i("slot7_rd_not_empty", int'(bus.fifoEmpty), 0);
    chk("slot7_rd_word0", bus.fifoOut, pack_group(0));
    step();
    bus.rden = 1'b0;
    chk("slot7_rd_word1", bus.fifoOut, pack_group(8));
    chk_i("slot7_rd_now_empty", int'(bus.fifoEmpty), 1);
    chk_i("slot7_rd_accepted", acc_q.size(), 16);

    // Back-pressure: 136 moves with no reads until the FIFO fills
    do_reset();
    for (int c = 0; c < 400 && acc_q.size() < 128; c++) begin
      bus.mv_valid = 1'b1;
      bus.mv_data  = move_t'(acc_q.size() + 1);
      step();
    end
    chk_i("bp_accepted_128", acc_q.size(), 128);
    chk_i("bp_ready_low", int'(bus.mv_ready), 0);
    bus.mv_data = move_t'(129);
    step();
    step();
    chk_i("bp_no_extra_accept", acc_q.size(), 128);
    bus.rden = 1'b1;
    step();
    bus.rden = 1'b0;
    chk_i("bp_ready_back", int'(bus.mv_ready), 1);
    chk("bp_first_word", bus.fifoOut, pack_group(0));
    for (int c = 0; c < 400 && acc_q.size() < 136; c++) begin
      bus.rden     = 1'b1;
      bus.mv_valid = 1'b1;
      bus.mv_data  = move_t'(acc_q.size() + 1);
      step();
    end
    bus.mv_valid = 1'b0;
    bus.gen_last = 1'b1;
    step();
    bus.gen_last = 1'b0;
    drain_until_done("bp", 400, 1'b0);
    compare_stream("bp");

    // Reset pulse with five words stored and a partial word pending
    do_reset();
    for (int i = 0; i < 51; i++) begin
      bus.mv_valid = 1'b1;
      bus.mv_data  = move_t'(32'h3000 + i);
      step();
    end
    bus.mv_valid = 1'b0;
    bus.rden = 1'b1;
    step();
    bus.rden = 1'b0;
    chk("rst_pre_word", bus.fifoOut, pack_group(0));
    do_reset();
    for (int i = 0; i < 2; i++) begin
      bus.mv_valid = 1'b1;
      bus.mv_data  = move_t'(32'h3F000 + i);
      step();
    end
    bus.mv_valid = 1'b0;
    bus.gen_last = 1'b1;
    step();
    bus.gen_last = 1'b0;
    drain_until_done("rst_fresh", 64, 1'b0);
    compare_stream("rst_fresh");

    // Randomised runs against the stream model
    for (int it = 0; it < 6; it++) begin
      do_reset();
      n_rand  = $urandom_range(0, 150);
      gl_sent = 1'b0;
      for (int c = 0; c < 3000 && !gl_sent; c++) begin
        bus.rden     = ($urandom_range(0, 3) == 0);
        bus.mv_data  = move_t'($urandom);
        bus.mv_valid = (acc_q.size() < n_rand) && ($urandom_range(0, 1) == 1);
        bus.gen_last = 1'b0;
        if (acc_q.size() == n_rand) begin
          bus.gen_last = 1'b1;
          bus.mv_valid = 1'b0;
        end else if (acc_q.size() == n_rand - 1 && bus.mv_valid && bus.mv_ready
                     && $urandom_range(0, 1) == 1) begin
          bus.gen_last = 1'b1;
        end
        if (bus.gen_last) gl_sent = 1'b1;
        step();
      end
      chk_i("rand_gen_last_bound", int'(gl_sent), 1);
      drain_until_done("rand", 3000, 1'b1);
      chk_i("rand_accepted", acc_q.size(), n_rand);
      compare_stream("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
